// File: rtl/seq_mul_if.sv
// seq_mul_if: start/valid handshake bundle for the sequential multiplier.
//   master : drives start, sgn, in1, in2; observes ready, valid, out, out_hi, flags
//   slave  : the multiplier side of the same signals
interface seq_mul_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sgn;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             ready;
    logic             valid;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_hi;
    logic [3:0]       flags;

    modport master (
        output start, sgn, in1, in2,
        input  ready, valid, out, out_hi, flags
    );

    modport slave (
        input  start, sgn, in1, in2,
        output ready, valid, out, out_hi, flags
    );
endinterface

// File: rtl/seq_mul.sv
// seq_mul: radix-2 shift-add multiplier, WIDTH-bit operands, 2*WIDTH-bit product,
// runtime signed/unsigned mode, start/valid handshake.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : seq_mul_if.slave
//            start/sgn/in1/in2 sampled when ready=1
//            ready = idle, valid = one-cycle result pulse
//            out/out_hi = product low/high halves, flags = {N,Z,C,V}
// Optional build macro: SEQ_MUL_EARLY_EXIT_EN -- leave CALC as soon as the
// remaining multiplier bits are all zero (same results, shorter latency).
module seq_mul #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    seq_mul_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    state_t             state;
    logic               sgn_r;
    logic               neg;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [2*WIDTH-1:0] p;
    logic [WIDTH-1:0]   p_hi;
    logic [3:0]         flags_nxt;
    logic               last_iter;

    // Operand magnitudes; negating the most negative value wraps to 2^(WIDTH-1),
    // which is exactly its magnitude as an unsigned number.
    always_comb begin
        mag1 = bus.in1;
        mag2 = bus.in2;
        if (bus.sgn && bus.in1[WIDTH-1]) mag1 = '0 - bus.in1;
        if (bus.sgn && bus.in2[WIDTH-1]) mag2 = '0 - bus.in2;
    end

    always_comb begin
        p         = neg ? ('0 - acc) : acc;
        p_hi      = p[2*WIDTH-1:WIDTH];
        flags_nxt = '0;
        flags_nxt[3] = sgn_r & p[2*WIDTH-1];
        flags_nxt[2] = (p == '0);
        flags_nxt[1] = |p_hi;
        flags_nxt[0] = sgn_r ? (p_hi != {WIDTH{p[WIDTH-1]}}) : (|p_hi);
    end

`ifdef SEQ_MUL_EARLY_EXIT_EN
    // mplier[WIDTH-1:1] is the multiplier register after this iteration's shift.
    assign last_iter = (cnt == CW'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
`else
    assign last_iter = (cnt == CW'(WIDTH - 1));
`endif

    assign bus.ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            sgn_r      <= 1'b0;
            neg        <= 1'b0;
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            cnt        <= '0;
            bus.valid  <= 1'b0;
            bus.out    <= '0;
            bus.out_hi <= '0;
            bus.flags  <= '0;
        end else begin
            bus.valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sgn_r  <= bus.sgn;
                        neg    <= bus.sgn & (bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1]);
                        mcand  <= {{WIDTH{1'b0}}, mag1};
                        mplier <= mag2;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last_iter) state <= FIN;
                end
                FIN: begin
                    bus.out    <= p[WIDTH-1:0];
                    bus.out_hi <= p_hi;
                    bus.flags  <= flags_nxt;
                    bus.valid  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mul.sv
// tb_seq_mul: self-checking bench for seq_mul (WIDTH=32).
// Directed cases with hand-computed constants, handshake/reset corner cases,
// then randomized operands checked against 64-bit integer arithmetic.
module tb_seq_mul;
    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    seq_mul_if #(.WIDTH(W)) mif ();

    seq_mul #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain 64-bit multiplication.
    function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint     x;
        longint     y;
        logic [63:0] ua;
        logic [63:0] ub;
        if (s) begin
            x = $signed(a);
            y = $signed(b);
            return 64'(x * y);
        end
        ua = {32'b0, a};
        ub = {32'b0, b};
        return ua * ub;
    endfunction

    function automatic logic [3:0] ref_flags(input logic s, input logic [63:0] p);
        logic n, z, c, v;
        n = s & p[63];
        z = (p == 64'd0);
        c = (p[63:32] != 32'd0);
        v = s ? (p[63:32] != {32{p[31]}}) : c;
        return {n, z, c, v};
    endfunction

    // Edges from the accepting edge to the edge after which valid is high: k+1.
    function automatic int exp_lat(input logic s, input logic [31:0] b);
        int k;
`ifdef SEQ_MUL_EARLY_EXIT_EN
        logic [31:0] m;
        m = (s && b[31]) ? (32'd0 - b) : b;
        k = 1;
        for (int i = 0; i < 32; i++)
            if (m[i]) k = i + 1;
`else
        k = W;
        if (s && b == 32'hDEAD_BEEF) k = W;  // operands do not affect fixed latency
`endif
        return k + 1;
    endfunction

    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
        int guard;
        guard = 0;
        while (mif.ready !== 1'b1 && guard < 100) begin
            tick;
            guard++;
        end
        check("ready_before_issue", 64'(mif.ready), 64'd1);
        mif.sgn   = s;
        mif.in1   = a;
        mif.in2   = b;
        mif.start = 1'b1;
        tick;
        mif.start = 1'b0;
    endtask

    // Returns number of edges until valid is seen, or -1 on timeout.
    task automatic wait_valid(output int n);
        n = 0;
        while (n < 100) begin
            tick;
            n++;
            if (mif.valid === 1'b1) return;
        end
        n = -1;
    endtask

    task automatic check_result(input string tag, input logic [63:0] ep, input logic [3:0] ef);
        check({tag, "_prod"}, {mif.out_hi, mif.out}, ep);
        check({tag, "_flags"}, 64'(mif.flags), 64'(ef));
    endtask

    task automatic do_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] ep, input logic [3:0] ef);
        int n;
        issue(s, a, b);
        wait_valid(n);
        check({tag, "_lat"}, 64'(n), 64'(exp_lat(s, b)));
        check_result(tag, ep, ef);
        tick;
        check({tag, "_pulse"}, 64'(mif.valid), 64'd0);
    endtask

    task automatic count_valids(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            tick;
            if (mif.valid === 1'b1) cnt++;
        end
    endtask

    initial begin
        int          n;
        int          nv;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] ep;

        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        mif.start = 1'b0;
        mif.sgn   = 1'b0;
        mif.in1   = '0;
        mif.in2   = '0;
        tick;
        tick;
        check("rst_ready", 64'(mif.ready), 64'd1);
        check("rst_valid", 64'(mif.valid), 64'd0);
        check("rst_out", {mif.out_hi, mif.out}, 64'd0);
        check("rst_flags", 64'(mif.flags), 64'd0);
        rst_n = 1'b1;
        tick;

        // Directed cases with hand-computed products and flags.
        do_op("s7xm3", 1'b1, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 4'b1010);
        do_op("u_ffx2", 1'b0, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 4'b0011);
        do_op("s_ffx2", 1'b1, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1010);
        do_op("s_minxmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 4'b0011);
        do_op("zero", 1'b1, 32'd0, 32'd5, 64'd0, 4'b0100);
        do_op("one", 1'b0, 32'h1234_5678, 32'd1, 64'h0000_0000_1234_5678, 4'b0000);
        do_op("bit8", 1'b0, 32'd3, 32'h0000_0100, 64'h0000_0000_0000_0300, 4'b0000);

        // start pulsed mid-CALC must be ignored.
        issue(1'b1, 32'd7, 32'hFFFF_FFFD);
        repeat (5) tick;
        check("midcalc_ready", 64'(mif.ready), 64'd0);
        mif.sgn   = 1'b0;
        mif.in1   = 32'd123;
        mif.in2   = 32'd456;
        mif.start = 1'b1;
        tick;
        mif.start = 1'b0;
        wait_valid(n);
        check("midcalc_lat", 64'(n < 0 ? -1 : n + 6), 64'(exp_lat(1'b1, 32'hFFFF_FFFD)));
        check_result("midcalc", 64'hFFFF_FFFF_FFFF_FFEB, 4'b1010);
        count_valids(40, nv);
        check("midcalc_extra_valid", 64'(nv), 64'd0);

        // start held in the valid cycle is accepted immediately.
        issue(1'b0, 32'd1000, 32'd3000);
        wait_valid(n);
        check("b2b_first_lat", 64'(n), 64'(exp_lat(1'b0, 32'd3000)));
        check_result("b2b_first", 64'd3_000_000, 4'b0000);
        check("b2b_ready_in_valid", 64'(mif.ready), 64'd1);
        mif.sgn   = 1'b1;
        mif.in1   = 32'hFFFF_FFF0;
        mif.in2   = 32'd16;
        mif.start = 1'b1;
        tick;
        mif.start = 1'b0;
        check("b2b_accepted", 64'(mif.ready), 64'd0);
        wait_valid(n);
        check("b2b_second_lat", 64'(n), 64'(exp_lat(1'b1, 32'd16)));
        check_result("b2b_second", 64'hFFFF_FFFF_FFFF_FF00, 4'b1010);
        tick;

        // Reset mid-CALC discards the operation (previous outputs are nonzero).
        issue(1'b0, 32'hABCD_0123, 32'hFFFF_0001);
        repeat (10) tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        check("midrst_ready", 64'(mif.ready), 64'd1);
        check("midrst_valid", 64'(mif.valid), 64'd0);
        check("midrst_out", {mif.out_hi, mif.out}, 64'd0);
        check("midrst_flags", 64'(mif.flags), 64'd0);
        count_valids(40, nv);
        check("midrst_no_valid", 64'(nv), 64'd0);
        do_op("after_rst", 1'b0, 32'hABCD_0123, 32'hFFFF_0001,
              ref_prod(1'b0, 32'hABCD_0123, 32'hFFFF_0001),
              ref_flags(1'b0, ref_prod(1'b0, 32'hABCD_0123, 32'hFFFF_0001)));

        // Randomized operands, with corner values mixed in.
        for (int i = 0; i < 1400; i++) begin
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: a = 32'h8000_0000;
                1: a = 32'hFFFF_FFFF;
                2: a = 32'd0;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: b = 32'h8000_0000;
                1: b = 32'd1;
                2: b = 32'(1) << $urandom_range(0, 31);
                3: b = $urandom_range(0, 255);
                default: b = $urandom;
            endcase
            ep = ref_prod(s, a, b);
            do_op("rand", s, a, b, ep, ref_flags(s, ep));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
